// File: rtl/cyclic_right_rotator_128bit_if.sv
// Valid/ready handshake bundle for the 128-bit cyclic right rotator: input word/amount channel,
// output result channel and busy flag.
interface cyclic_right_rotator_128bit_if #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned AMT_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amount;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_amount, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Rotation engine side
    modport slave (
        input  in_valid, in_data, in_amount, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/cyclic_right_rotator_128bit.sv
// Handshaked cyclic right-rotation engine; bit-serial by default, one-cycle barrel rotate
// when CRR_SINGLE_CYCLE_EN is defined.
module cyclic_right_rotator_128bit #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned AMT_W = 7
) (
    input  logic clock,
    input  logic reset,
    cyclic_right_rotator_128bit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_r, data_d;
    logic             in_ready_r, out_valid_r, busy_r;

`ifdef CRR_SINGLE_CYCLE_EN
    logic [WIDTH-1:0] rotated_c;

    // Barrel rotate; an amount of 0 shifts the wrap term fully out, leaving in_data unchanged
    assign rotated_c = (bus.in_data >> bus.in_amount)
                     | (bus.in_data << (WIDTH - 32'(bus.in_amount)));
`else
    logic [AMT_W-1:0] count_r, count_d;
`endif

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        data_d  = data_r;
`ifndef CRR_SINGLE_CYCLE_EN
        count_d = count_r;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef CRR_SINGLE_CYCLE_EN
                    data_d  = rotated_c;
                    state_d = DONE;
`else
                    data_d  = bus.in_data;
                    count_d = bus.in_amount;
                    state_d = (bus.in_amount == AMT_W'(0)) ? DONE : SHIFT;
`endif
                end
            end
            SHIFT: begin
`ifdef CRR_SINGLE_CYCLE_EN
                state_d = DONE;
`else
                data_d  = {data_r[0], data_r[WIDTH-1:1]};
                count_d = count_r - AMT_W'(1);
                if (count_r == AMT_W'(1)) state_d = DONE;
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and flags; flags follow the next state so they track the registered state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            data_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifndef CRR_SINGLE_CYCLE_EN
            count_r     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_r      <= data_d;
            in_ready_r  <= (state_d == IDLE);
            out_valid_r <= (state_d == DONE);
            busy_r      <= (state_d != IDLE);
`ifndef CRR_SINGLE_CYCLE_EN
            count_r     <= count_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_cyclic_right_rotator_128bit.sv
// Randomized self-checking bench for cyclic_right_rotator_128bit against a shift/or rotation model.
module tb_cyclic_right_rotator_128bit;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned AMT_W = 7;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    cyclic_right_rotator_128bit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    cyclic_right_rotator_128bit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int k);
        return (x >> k) | (x << (WIDTH - k));
    endfunction

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int k);
        return (x << k) | (x >> (WIDTH - k));
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Edges after the accepting edge before out_valid is seen
    function automatic int exp_lat(input int n);
`ifdef CRR_SINGLE_CYCLE_EN
        return 0;
`else
        return (n == 0) ? 0 : n;
`endif
    endfunction

    // Offer one word from posedge+1; return the result and edges waited after the accepting edge
    task automatic do_word(input logic [WIDTH-1:0] d, input int amt,
                           output logic [WIDTH-1:0] res, output int lat, output bit tmo);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amount = AMT_W'(amt);
        @(posedge clock); #1;
        bus.in_valid  = 1'b0;
        bus.in_data   = rand_word();
        bus.in_amount = AMT_W'($urandom());
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clock); #1;
            lat++;
        end
        tmo = !bus.out_valid;
        res = bus.out_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amount = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        vectors++;
        if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] d, r, exp;
        int lat; bit tmo;
        d = '0; d[WIDTH-1] = 1'b1; d[0] = 1'b1;
        exp = '0; exp[WIDTH-1] = 1'b1; exp[WIDTH-2] = 1'b1;
        bus.out_ready = 1'b1;
        do_word(d, 1, r, lat, tmo);
        vectors++;
        if (tmo || r !== exp) begin miscompares++; $display("FAIL basic_data got %h want %h", r, exp); end
        vectors++;
        if (lat != exp_lat(1)) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", lat, exp_lat(1)); end
        vectors++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL basic_done_flags got busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
        end
        @(posedge clock); #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release got ov=%b ir=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_zero_amount();
        logic [WIDTH-1:0] d, r;
        int lat; bit tmo;
        d = {4{32'hDEADBEEF}};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_word(d, 0, r, lat, tmo);
            vectors++;
            if (tmo || r !== d || lat != 0) begin
                miscompares++; $display("FAIL zero_amt[%0d] got %h lat %0d want %h lat 0", i, r, lat, d);
            end
            vectors++;
            if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_amt_no_overlap got in_ready=%b want 0", bus.in_ready); end
            @(posedge clock); #1;
            vectors++;
            if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_amt_idle got in_ready=%b want 1", bus.in_ready); end
        end
    endtask

    task automatic test_max_amount();
        logic [WIDTH-1:0] d, r, exp;
        int lat; bit tmo;
        d = '0; d[0] = 1'b1;
        exp = '0; exp[1] = 1'b1;
        bus.out_ready = 1'b1;
        do_word(d, 127, r, lat, tmo);
        vectors++;
        if (tmo || r !== exp) begin miscompares++; $display("FAIL max_amt_data got %h want %h", r, exp); end
        vectors++;
        if (lat != exp_lat(127)) begin miscompares++; $display("FAIL max_amt_latency got %0d want %0d", lat, exp_lat(127)); end
        @(posedge clock); #1;
    endtask

    task automatic test_hold_done();
        logic [WIDTH-1:0] d, r, exp;
        int amt, lat; bit tmo;
        d = rand_word(); amt = $urandom_range(1, 20);
        exp = rotr(d, amt);
        bus.out_ready = 1'b0;
        do_word(d, amt, r, lat, tmo);
        vectors++;
        if (tmo || r !== exp) begin miscompares++; $display("FAIL hold_data got %h want %h", r, exp); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = i[0];
            bus.in_data   = rand_word();
            bus.in_amount = AMT_W'($urandom());
            @(posedge clock); #1;
            vectors++;
            if (bus.out_data !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable[%0d] got %h ov=%b ir=%b want %h 1 0", i, bus.out_data, bus.out_valid, bus.in_ready, exp);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== exp) begin
            miscompares++;
            $display("FAIL hold_release got ov=%b ir=%b data %h want 0 1 %h", bus.out_valid, bus.in_ready, bus.out_data, exp);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = rand_word();
        bus.in_amount = AMT_W'(100);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        repeat (39) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        vectors++;
        if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got data %h ov=%b ir=%b busy=%b want 0 0 1 0", bus.out_data, bus.out_valid, bus.in_ready, bus.busy);
        end
        @(posedge clock); #4 reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen || bus.out_data !== '0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_abort got seen=%b data %h ir=%b want 0 0 1", seen, bus.out_data, bus.in_ready);
        end
    endtask

    task automatic test_round_trip();
        logic [WIDTH-1:0] w, r;
        int k, lat; bit tmo;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            w = rand_word();
            k = $urandom_range(0, WIDTH - 1);
            if (bus.in_ready !== 1'b1) begin
                vectors++; miscompares++;
                $display("FAIL round_trip_ready[%0d] got in_ready=%b want 1", i, bus.in_ready);
            end
            do_word(rotl(w, k), k, r, lat, tmo);
            vectors++;
            if (tmo || r !== w || lat != exp_lat(k)) begin
                miscompares++;
                $display("FAIL round_trip[%0d] k=%0d got %h lat %0d want %h lat %0d", i, k, r, lat, w, exp_lat(k));
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_zero_amount();
        test_max_amount();
        test_hold_done();
        test_async_reset();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cyclic_right_rotator_128bit.md
# cyclic_right_rotator_128bit

Handshaked cyclic right-rotation engine, the opposite-direction counterpart to the team's 128-bit cyclic left-shift register. Accepts a 128-bit word and a rotate amount over a valid/ready input port, rotates the word right by that many bit positions, and presents the result on a valid/ready output port. It sits between a word producer and a consumer in the shift-register experiment datapath. It undoes a prior left rotation of the same amount.

## Interface
- WIDTH, 128, data word width in bits; must be a power of two ≥ 2.
- AMT_W, 7, rotate-amount width; equals log2(WIDTH).

- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  producer offers in_data/in_amount.
- in_ready  output  1  engine can accept; high only in IDLE.
- in_data  input  WIDTH  word to rotate.
- in_amount  input  AMT_W  right-rotate distance, 0..WIDTH-1.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  rotated word, registered.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0, rotating.
  - DONE: out_valid=1, in_ready=0.
- Internal registers: data_r[WIDTH-1:0] drives out_data; count_r[AMT_W-1:0]; state.
- IDLE, on in_valid&&in_ready:
  - data_r<=in_data, count_r<=in_amount.
  - Next state is DONE if in_amount==0, else SHIFT.
- IDLE, without that handshake: state and data_r hold.
- SHIFT, each cycle:
  - data_r<={data_r[0], data_r[WIDTH-1:1]}, a one-bit right rotate where the LSB wraps to the MSB.
  - count_r<=count_r-1.
  - When count_r==1 on this cycle, next state is DONE.
- DONE: hold data_r. On out_ready go to IDLE; otherwise stay, with out_data stable.
- Amount is unsigned and taken modulo WIDTH by its width; no saturation and no error flag.
- in_data/in_amount are ignored outside the IDLE handshake. in_valid in SHIFT/DONE has no effect.
- out_ready outside DONE has no effect.
- A new word can never overlap one in progress. There is no same-cycle DONE→accept; IDLE always lasts at least one cycle.

## Timing
- Reset values, applied asynchronously on reset assertion:
  - state=IDLE, data_r=0, count_r=0.
  - out_data=0, out_valid=0, busy=0, in_ready=1.
- Reset asserted mid-SHIFT or mid-DONE aborts the word with no output. The first post-reset edge with reset low behaves as IDLE.
- Latency from the accepting edge k:
  - amount N=0: out_valid high after edge k.
  - amount N>0: out_valid high after edge k+N.
- Throughput (non-fast build): one word per N+2 cycles minimum, with out_ready held high.
- out_valid falls on the edge where out_valid&&out_ready. in_ready rises on that same edge.
- in_ready, out_valid and busy are decoded from the registered state only, with no combinational path from inputs.

## Configuration
- Macro CRR_SINGLE_CYCLE_EN.
- Defined: SHIFT is never entered. On accept, data_r<=rotate-right of in_data by in_amount, computed in one cycle with a combinational barrel rotator, and the engine goes straight to DONE. Latency is 1 edge for every amount; count_r is unused and stays 0.
- Undefined: the bit-serial behaviour above, N-cycle SHIFT state, and no barrel rotator instantiated.
- Output values are identical in both builds; only latency differs.

## Test plan
- Reset, then in_data=0x8000...0001, in_amount=1, out_ready=1 → out_data=0xC000...0000 one edge after the accept edge plus one SHIFT cycle.
- in_amount=0, in_data=0xDEADBEEF repeated ×4 → out_valid after 1 edge, out_data equal to in_data. The next accept is no earlier than 2 edges after the accept.
- in_amount=127, in_data=0x0000...0001 → out_data=0x0000...0002 after 127 SHIFT cycles (1 edge in the single-cycle build).
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid with new data → out_data stable, in_ready=0. Release out_ready → IDLE next edge.
- Assert reset asynchronously (between edges) at SHIFT count 40 of a 100-bit rotate → out_data=0, out_valid=0, in_ready=1 immediately, with no result emitted.
- Round-trip: left-rotate random words by random k (software model), feed them with in_amount=k → out_data equals the original word for 1000 vectors.
